// File: rtl/carry_save_resolver.sv
// carry_save_resolver
//
// Carry-propagate stage that sits directly after the 3:2 compressor tree. It turns the
// final carry-save pair (in_s, in_c) into a plain binary sum. The add is segmented:
// one SEG_LEN-bit slice is resolved per cycle, lowest slice first, and the carry
// between slices is held in a register. This keeps the full-width carry chain off the
// critical path.
//
// Parameters:
//   BIT_LEN  width of in_s / in_c. in_c is already weight-aligned (no shift here).
//   SEG_LEN  slice width resolved per cycle. BIT_LEN must be a multiple of SEG_LEN.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   (in_s, in_c) valid
//   in_ready   block can accept a pair this cycle (combinational, independent of in_valid)
//   in_s       sum vector from the compressor tree
//   in_c       carry vector from the compressor tree
//   out_valid  out_sum holds a completed result
//   out_ready  consumer accepts out_sum
//   out_sum    in_s + in_c over BIT_LEN+1 bits; MSB is the final carry-out
//   busy       high while slices are being resolved

module carry_save_resolver #(
    parameter int unsigned BIT_LEN = 16,
    parameter int unsigned SEG_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BIT_LEN-1:0] in_s,
    input  logic [BIT_LEN-1:0] in_c,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIT_LEN:0]   out_sum,
    output logic               busy
);

    localparam int unsigned NUM_SEG = BIT_LEN / SEG_LEN;
    // Keep the index at least one bit wide so the NUM_SEG == 1 case still elaborates.
    localparam int unsigned SegW = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam logic [SegW-1:0] LastSeg = SegW'(NUM_SEG - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAdd  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    if ((BIT_LEN % SEG_LEN) != 0) begin : g_bad_seg_len
        $error("carry_save_resolver: BIT_LEN must be a multiple of SEG_LEN");
    end

    logic [1:0]         state_q,   state_d;
    logic [BIT_LEN-1:0] s_q,       s_d;
    logic [BIT_LEN-1:0] c_q,       c_d;
    logic [SegW-1:0]    seg_idx_q, seg_idx_d;
    logic               carry_q,   carry_d;
    logic [BIT_LEN:0]   sum_q,     sum_d;

    logic               accept;
    logic [31:0]        seg_base;
    logic [SEG_LEN-1:0] s_slice;
    logic [SEG_LEN-1:0] c_slice;
    logic [SEG_LEN:0]   slice_add;

    // A finished result can be replaced in the same cycle it is consumed, which is what
    // gives the back-to-back NUM_SEG+1 cycle throughput.
    always_comb begin
        in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
        accept   = in_valid && in_ready;
    end

    // One slice of the carry-propagate add: both operand slices plus the carry that
    // came out of the slice below on the previous cycle.
    always_comb begin
        seg_base  = 32'(seg_idx_q) * SEG_LEN;
        s_slice   = s_q[seg_base +: SEG_LEN];
        c_slice   = c_q[seg_base +: SEG_LEN];
        slice_add = {1'b0, s_slice} + {1'b0, c_slice} + (SEG_LEN + 1)'(carry_q);
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        c_d       = c_q;
        seg_idx_d = seg_idx_q;
        carry_d   = carry_q;
        sum_d     = sum_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    s_d       = in_s;
                    c_d       = in_c;
                    carry_d   = 1'b0;
                    seg_idx_d = '0;
                    state_d   = StAdd;
                end
            end

            StAdd: begin
                sum_d[seg_base +: SEG_LEN] = slice_add[SEG_LEN-1:0];
                carry_d                    = slice_add[SEG_LEN];
                if (seg_idx_q == LastSeg) begin
                    // Top slice: its carry-out is the extra result bit.
                    sum_d[BIT_LEN] = slice_add[SEG_LEN];
                    seg_idx_d      = '0;
                    state_d        = StDone;
                end else begin
                    seg_idx_d = seg_idx_q + 1'b1;
                end
            end

            StDone: begin
                if (accept) begin
                    s_d       = in_s;
                    c_d       = in_c;
                    carry_d   = 1'b0;
                    seg_idx_d = '0;
                    state_d   = StAdd;
                end else if (out_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            s_q       <= '0;
            c_q       <= '0;
            seg_idx_q <= '0;
            carry_q   <= 1'b0;
            sum_q     <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            c_q       <= c_d;
            seg_idx_q <= seg_idx_d;
            carry_q   <= carry_d;
            sum_q     <= sum_d;
        end
    end

    always_comb begin
        out_valid = (state_q == StDone);
        busy      = (state_q == StAdd);
        out_sum   = sum_q;
    end

    // A stalled result must stay put until the consumer takes it.
    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_sum)));

    a_valid_not_busy : assert property (@(posedge clk) disable iff (rst)
        !(out_valid && busy));

endmodule

// File: doc/carry_save_resolver.md
Name: carry_save_resolver

Overview:
Carry-propagate stage directly downstream of compressor_tree_3_to_2. Takes the final carry-save pair (S, C) from the tree and resolves S + C into a binary result. The resolution is segmented: one SEG_LEN-bit slice per cycle, lowest slice first, with a registered inter-slice carry. This keeps the wide BLS12-381 adders off the critical path. Valid/ready handshakes are used on both sides.

Parameters:
BIT_LEN, 16, width of in_s / in_c (matches compressor tree BIT_LEN); C input is already weight-aligned (no shift applied here)
SEG_LEN, 8, slice width added per cycle; BIT_LEN % SEG_LEN must be 0 (elaboration-time $error otherwise)
NUM_SEG, BIT_LEN/SEG_LEN, derived; number of add cycles per operation

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  (in_s, in_c) valid
in_ready  output  1  block can accept a pair this cycle
in_s  input  BIT_LEN  sum vector from compressor tree
in_c  input  BIT_LEN  carry vector from compressor tree
out_valid  output  1  out_sum valid
out_ready  input  1  consumer accepts out_sum
out_sum  output  BIT_LEN+1  in_s + in_c; MSB is final carry-out
busy  output  1  high in ADD state

Behaviour:
- Reset: state IDLE, out_valid=0, out_sum=0, busy=0, seg_idx=0, carry_reg=0, operand regs=0. Reset at any point, including mid-ADD or DONE, discards the operation. No output is produced for it.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational and does not depend on in_valid.
- Accept: at a rising edge where in_valid && in_ready:
  - latch in_s and in_c.
  - set carry_reg=0 and seg_idx=0.
  - go to ADD.
  - inputs are ignored at every other edge.
- States:
  - IDLE: out_valid=0. On accept, go to ADD.
  - ADD: busy=1, out_valid=0. Each cycle:
    - compute {cout, slice} = s_reg[seg_idx*SEG_LEN +: SEG_LEN] + c_reg[same slice] + carry_reg.
    - write slice into result bits [seg_idx*SEG_LEN +: SEG_LEN].
    - carry_reg <= cout.
    - seg_idx++.
    - on the cycle with seg_idx==NUM_SEG-1, also write result[BIT_LEN]=cout and go to DONE.
  - DONE: out_valid=1, out_sum stable.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=1 and in_valid=1: back-to-back accept, go straight to ADD. out_valid drops for that next cycle.
    - out_ready=0: hold out_sum and out_valid indefinitely.
- Latency: out_valid rises exactly NUM_SEG cycles after the accept edge (2 cycles for the defaults). Throughput is one result per NUM_SEG+1 cycles.
- out_sum holds the last result while in IDLE. It is updated slice-by-slice only in ADD. It is only meaningful while out_valid=1.
- Arithmetic is full-precision: out_sum = in_s + in_c, exact over BIT_LEN+1 bits, never truncated.
- SEG_LEN==BIT_LEN is legal. NUM_SEG=1: a single ADD cycle, latency 1.
- out_ready while out_valid=0 has no effect.
- The block never drops or duplicates a result. out_valid is never asserted without a completed ADD sequence since the last accept.

Test Plan:
- Basic: in_s=0x0219, in_c=0x01DC, out_ready=1. Required: out_sum=0x003F5 (9 stacked terms 0x1..0x1FF), out_valid exactly 2 cycles after the accept edge and high for 1 cycle.
- Cross-slice carry: in_s=0x00FF, in_c=0x0001. Required: out_sum=0x00100, confirming carry_reg propagates from slice 0 into slice 1.
- Overflow: in_s=0xFFFF, in_c=0x0001. Required: out_sum=0x10000 (MSB=1). Also in_s=0xFFFF, in_c=0xFFFF. Required: out_sum=0x1FFFE.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles after out_valid rises. Required: out_sum and out_valid unchanged, in_ready=0.
  - Then raise out_ready with in_valid=1, in_s=0x1234, in_c=0x0001. Required: the same edge accepts, and the next out_sum=0x01235 appears 2 cycles later.
- Reset mid-operation: assert rst for 1 cycle during the first ADD cycle. Required next cycle: out_valid=0, out_sum=0, in_ready=1, busy=0. A subsequent pair resolves correctly.
- Config sweep with BIT_LEN=32: SEG_LEN=8 gives 4-cycle latency; SEG_LEN=32 gives 1-cycle latency. Required: 1000 random pairs match a reference S+C in both configurations.
